// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache (c0) and dcache (c1).
// One transaction in flight; responses whose address does not match the outstanding request are dropped.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              c0_req_valid_i,
    output logic              c0_req_ready_o,
    input  logic [ADDR_W-1:0] c0_addr_i,
    input  logic              c0_we_i,
    input  logic [LINE_W-1:0] c0_data_wr_i,
    output logic              c0_rsp_valid_o,
    input  logic              c0_rsp_ready_i,
    output logic [LINE_W-1:0] c0_rsp_data_o,
    output logic [ADDR_W-1:0] c0_rsp_addr_o,

    input  logic              c1_req_valid_i,
    output logic              c1_req_ready_o,
    input  logic [ADDR_W-1:0] c1_addr_i,
    input  logic              c1_we_i,
    input  logic [LINE_W-1:0] c1_data_wr_i,
    output logic              c1_rsp_valid_o,
    input  logic              c1_rsp_ready_i,
    output logic [LINE_W-1:0] c1_rsp_data_o,
    output logic [ADDR_W-1:0] c1_rsp_addr_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [LINE_W-1:0] mem_data_wr_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,
    input  logic [LINE_W-1:0] mem_data_line_i,
    input  logic [ADDR_W-1:0] mem_rsp_addr_i,

    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [LINE_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } rsp_t;

    state_e     state_q;
    logic       owner_q;
    logic       last_grant_q;
    logic       err_q;
    req_t       req_q;
    rsp_t       rsp_q;
    logic       mem_req_vld_q;
    logic       mem_rsp_rdy_q;
    logic [1:0] rsp_vld_q;

    logic       gnt0, gnt1;
    req_t       req_d;
    logic       own_rsp_rdy;
    logic       addr_match;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !rst_i) begin
            gnt0 = c0_req_valid_i && (!c1_req_valid_i || last_grant_q);
            gnt1 = c1_req_valid_i && (!c0_req_valid_i || !last_grant_q);
        end
    end

    always_comb begin
        req_d = '0;
        if (gnt1) begin
            req_d.addr = c1_addr_i;
            req_d.we   = c1_we_i;
            req_d.data = c1_data_wr_i;
        end else begin
            req_d.addr = c0_addr_i;
            req_d.we   = c0_we_i;
            req_d.data = c0_data_wr_i;
        end
    end

    assign own_rsp_rdy = owner_q ? c1_rsp_ready_i : c0_rsp_ready_i;
    assign addr_match  = (mem_rsp_addr_i == req_q.addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            err_q         <= 1'b0;
            req_q         <= '0;
            rsp_q         <= '0;
            mem_req_vld_q <= 1'b0;
            mem_rsp_rdy_q <= 1'b0;
            rsp_vld_q     <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        req_q         <= req_d;
                        owner_q       <= gnt1;
                        mem_req_vld_q <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_vld_q <= 1'b0;
                        mem_rsp_rdy_q <= 1'b1;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (addr_match) begin
                            rsp_q.addr         <= mem_rsp_addr_i;
                            rsp_q.data         <= mem_data_line_i;
                            mem_rsp_rdy_q      <= 1'b0;
                            rsp_vld_q[owner_q] <= 1'b1;
                            state_q            <= RSP;
                        end else begin
                            // Stray beat: swallow it and keep waiting for the real one.
                            err_q <= 1'b1;
                        end
                    end
                end
                RSP: begin
                    if (own_rsp_rdy) begin
                        rsp_vld_q    <= 2'b00;
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c0_req_ready_o  = gnt0;
    assign c1_req_ready_o  = gnt1;
    assign c0_rsp_valid_o  = rsp_vld_q[0];
    assign c1_rsp_valid_o  = rsp_vld_q[1];
    assign c0_rsp_data_o   = rsp_q.data;
    assign c1_rsp_data_o   = rsp_q.data;
    assign c0_rsp_addr_o   = rsp_q.addr;
    assign c1_rsp_addr_o   = rsp_q.addr;

    assign mem_addr_o      = req_q.addr;
    assign mem_we_o        = req_q.we;
    assign mem_data_wr_o   = req_q.data;
    assign mem_req_valid_o = mem_req_vld_q;
    assign mem_rsp_ready_o = mem_rsp_rdy_q;

    assign err_o           = err_q;

endmodule
